mmu_tile_sequencer: RTL and testbench

Sequences one matrix-multiply tile through the systolic-array datapath. On a start command it loads an ARRAY_DIM×ARRAY_DIM weight tile from the weight buffer through the weight FIFO into the MMU. It then streams num_rows activation rows from the unified buffer through the data FIFO into the MMU and writes the results into the accumulator. It sits between the control unit, which issues commands, and the UB/WB/FIFO/MMU/ACC strobes and addresses.

---
 rtl/sa_share.sv | 23 ++
 rtl/mmu_tile_sequencer_if.sv | 50 +++++
 rtl/mmu_seq_window.sv | 22 ++
 rtl/mmu_tile_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_mmu_tile_sequencer.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_share.sv
// Shared definitions for the systolic-array tile sequencer.
// Holds the default datapath geometry (MMU edge, FIFO depth, MMU pipeline
// latency, address width) and the sequencer state encoding.
package sa_share;

  localparam int ARRAY_DIM   = 16;  // MMU edge; weight rows per tile
  localparam int ADDR_WIDTH  = 8;   // UB/WB/ACC address width
  localparam int FIFO_DEPTH  = 4;   // stages in weight FIFO and data FIFO
  localparam int MMU_LATENCY = 32;  // data-FIFO row -> ACC input

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD_W = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD_W = ST_LOAD_W,
    S_STREAM = ST_STREAM,
    S_DONE   = ST_DONE
  } seq_state_e;

endpackage

// File: rtl/mmu_tile_sequencer_if.sv
// Command and datapath-strobe bundle for mmu_tile_sequencer.
//   master : control-unit side (drives commands, observes status/strobes)
//   slave  : sequencer side (accepts commands, drives status/strobes)
// Commands : start, abort, ub_base, wb_base, acc_base, num_rows, accumulate
// Status   : busy, done, err
// Strobes  : read_wb, read_ub, weight_fifo_en, mmu_load_weight_en,
//            data_fifo_en, mm_en, write_acc, acc_en, addrb (WB/UB read),
//            addra (ACC write)
interface mmu_tile_sequencer_if #(
  parameter int ADDR_WIDTH = sa_share::ADDR_WIDTH
);

  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] ub_base;
  logic [ADDR_WIDTH-1:0] wb_base;
  logic [ADDR_WIDTH-1:0] acc_base;
  logic [ADDR_WIDTH:0]   num_rows;
  logic                  accumulate;

  logic                  busy;
  logic                  done;
  logic                  err;

  logic                  read_wb;
  logic                  read_ub;
  logic                  weight_fifo_en;
  logic                  mmu_load_weight_en;
  logic                  data_fifo_en;
  logic                  mm_en;
  logic                  write_acc;
  logic                  acc_en;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [ADDR_WIDTH-1:0] addra;

  modport master (
    output start, abort, ub_base, wb_base, acc_base, num_rows, accumulate,
    input  busy, done, err,
    input  read_wb, read_ub, weight_fifo_en, mmu_load_weight_en,
    input  data_fifo_en, mm_en, write_acc, acc_en, addrb, addra
  );

  modport slave (
    input  start, abort, ub_base, wb_base, acc_base, num_rows, accumulate,
    output busy, done, err,
    output read_wb, read_ub, weight_fifo_en, mmu_load_weight_en,
    output data_fifo_en, mm_en, write_acc, acc_en, addrb, addra
  );

endinterface

// File: rtl/mmu_seq_window.sv
// Counter-window comparator.
// Reports whether the phase counter c lies in the inclusive range [lo, hi]
// and the offset c - lo, truncated to the address width so that address
// arithmetic downstream wraps naturally.
//   lo, hi, c : CW-bit window bounds and counter
//   in_win    : lo <= c <= hi
//   offset    : (c - lo) modulo 2^OW
module mmu_seq_window #(
  parameter int CW = 10,
  parameter int OW = 8
) (
  input  logic [CW-1:0] lo,
  input  logic [CW-1:0] hi,
  input  logic [CW-1:0] c,
  output logic          in_win,
  output logic [OW-1:0] offset
);

  assign in_win = (c >= lo) && (c <= hi);
  assign offset = OW'(c - lo);

endmodule

// File: rtl/mmu_tile_sequencer.sv
// Sequences one matrix-multiply tile: loads an ARRAY_DIM x ARRAY_DIM weight
// tile (WB -> weight FIFO -> MMU), then streams num_rows activation rows
// (UB -> data FIFO -> MMU) and writes the results into the accumulator.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : command inputs, status outputs, datapath strobes/addresses
// Every output is a register loaded from the decode of the *next* state and
// counter, so a strobe is visible in the same cycle its state/count is.
module mmu_tile_sequencer
  import sa_share::*;
#(
  parameter int ARRAY_DIM   = sa_share::ARRAY_DIM,
  parameter int ADDR_WIDTH  = sa_share::ADDR_WIDTH,
  parameter int FIFO_DEPTH  = sa_share::FIFO_DEPTH,
  parameter int MMU_LATENCY = sa_share::MMU_LATENCY
) (
  input logic                  clk,
  input logic                  reset_n,
  mmu_tile_sequencer_if.slave  bus
);

  localparam int CW = ADDR_WIDTH + 2;  // holds up to 2^AW + F + L

  // Strobe-group windows, one comparator each.
  localparam int G_RD_WB  = 0;
  localparam int G_WFIFO  = 1;
  localparam int G_MLOAD  = 2;
  localparam int G_RD_UB  = 3;
  localparam int G_DFIFO  = 4;
  localparam int G_WACC   = 5;
  localparam int NG       = 6;

  localparam logic [CW-1:0] LOAD_LAST = CW'(ARRAY_DIM + FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] ub_base;
    logic [ADDR_WIDTH-1:0] wb_base;
    logic [ADDR_WIDTH-1:0] acc_base;
    logic [ADDR_WIDTH:0]   num_rows;
    logic                  accumulate;
  } params_t;

  seq_state_e      state_q, state_d;
  logic [CW-1:0]   c_q, c_d;
  params_t         par_q, par_d;
  logic            err_d;
  logic [CW-1:0]   n_q, n_d;

  logic [CW-1:0]         win_lo  [NG];
  logic [CW-1:0]         win_hi  [NG];
  logic                  win_in  [NG];
  logic [ADDR_WIDTH-1:0] win_off [NG];

  logic                  load_d, stream_d;
  logic                  rd_wb_d, rd_ub_d, wacc_d;
  logic [ADDR_WIDTH-1:0] addrb_d, addra_d;

  assign n_q = CW'(par_q.num_rows);
  assign n_d = CW'(par_d.num_rows);

  // ---------------------------------------------------------------------
  // Next-state / counter / parameter latch
  // ---------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    c_d     = c_q + CW'(1);
    par_d   = par_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        c_d = '0;
        // abort outranks a same-cycle start, even from IDLE.
        if (bus.start && !bus.abort) begin
          if (bus.num_rows == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = S_LOAD_W;
            par_d   = '{ub_base:    bus.ub_base,
                        wb_base:    bus.wb_base,
                        acc_base:   bus.acc_base,
                        num_rows:   bus.num_rows,
                        accumulate: bus.accumulate};
          end
        end
      end
      S_LOAD_W: if (c_q == LOAD_LAST) state_d = S_STREAM;
      S_STREAM: if (c_q == n_q + CW'(FIFO_DEPTH + MMU_LATENCY)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && bus.abort) state_d = S_IDLE;

    // Counter restarts on every state entry.
    if (state_d != state_q) c_d = '0;
  end

  // ---------------------------------------------------------------------
  // Strobe windows evaluated on the next counter value
  // ---------------------------------------------------------------------
  always_comb begin
    win_lo[G_RD_WB] = '0;
    win_hi[G_RD_WB] = CW'(ARRAY_DIM - 1);
    win_lo[G_WFIFO] = CW'(1);
    win_hi[G_WFIFO] = CW'(ARRAY_DIM + FIFO_DEPTH);
    win_lo[G_MLOAD] = CW'(FIFO_DEPTH + 1);
    win_hi[G_MLOAD] = CW'(ARRAY_DIM + FIFO_DEPTH);
    // Stream windows only matter when n_d >= 1, so n_d - 1 never underflows
    // where it is used.
    win_lo[G_RD_UB] = '0;
    win_hi[G_RD_UB] = n_d - CW'(1);
    win_lo[G_DFIFO] = CW'(1);
    win_hi[G_DFIFO] = n_d + CW'(FIFO_DEPTH);
    win_lo[G_WACC]  = CW'(FIFO_DEPTH + MMU_LATENCY + 1);
    win_hi[G_WACC]  = n_d + CW'(FIFO_DEPTH + MMU_LATENCY);
  end

  for (genvar g = 0; g < NG; g++) begin : g_win
    mmu_seq_window #(.CW(CW), .OW(ADDR_WIDTH)) u_win (
      .lo     (win_lo[g]),
      .hi     (win_hi[g]),
      .c      (c_d),
      .in_win (win_in[g]),
      .offset (win_off[g])
    );
  end

  always_comb begin
    load_d   = (state_d == S_LOAD_W);
    stream_d = (state_d == S_STREAM);
    rd_wb_d  = load_d   && win_in[G_RD_WB];
    rd_ub_d  = stream_d && win_in[G_RD_UB];
    wacc_d   = stream_d && win_in[G_WACC];

    addrb_d = '0;
    if (rd_wb_d)      addrb_d = par_d.wb_base + win_off[G_RD_WB];
    else if (rd_ub_d) addrb_d = par_d.ub_base + win_off[G_RD_UB];

    addra_d = '0;
    if (wacc_d) addra_d = par_d.acc_base + win_off[G_WACC];
  end

  // ---------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q                <= S_IDLE;
      c_q                    <= '0;
      par_q                  <= '0;
      bus.busy               <= 1'b0;
      bus.done               <= 1'b0;
      bus.err                <= 1'b0;
      bus.read_wb            <= 1'b0;
      bus.read_ub            <= 1'b0;
      bus.weight_fifo_en     <= 1'b0;
      bus.mmu_load_weight_en <= 1'b0;
      bus.data_fifo_en       <= 1'b0;
      bus.mm_en              <= 1'b0;
      bus.write_acc          <= 1'b0;
      bus.acc_en             <= 1'b0;
      bus.addrb              <= '0;
      bus.addra              <= '0;
    end else begin
      state_q                <= state_d;
      c_q                    <= c_d;
      par_q                  <= par_d;
      bus.busy               <= (state_d != S_IDLE);
      bus.done               <= (state_d == S_DONE);
      bus.err                <= err_d;
      bus.read_wb            <= rd_wb_d;
      bus.read_ub            <= rd_ub_d;
      bus.weight_fifo_en     <= load_d && win_in[G_WFIFO];
      bus.mmu_load_weight_en <= load_d && win_in[G_MLOAD];
      bus.data_fifo_en       <= stream_d && win_in[G_DFIFO];
      bus.mm_en              <= stream_d;
      bus.write_acc          <= wacc_d;
      bus.acc_en             <= wacc_d && par_d.accumulate;
      bus.addrb              <= addrb_d;
      bus.addra              <= addra_d;
    end
  end

endmodule

// File: tb/tb_mmu_tile_sequencer.sv
// Self-checking bench for mmu_tile_sequencer. Expected outputs come from a
// cycle-offset model of the sequencing rules: given the cycle count since an
// accepted start and the command parameters, it states which strobes and
// addresses must be visible.
module tb_mmu_tile_sequencer;
  import sa_share::*;

  localparam int AW = 8;
  localparam int AD = ARRAY_DIM;
  localparam int F  = FIFO_DEPTH;
  localparam int L  = MMU_LATENCY;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          err;
    logic          read_wb;
    logic          read_ub;
    logic          weight_fifo_en;
    logic          mmu_load_weight_en;
    logic          data_fifo_en;
    logic          mm_en;
    logic          write_acc;
    logic          acc_en;
    logic [AW-1:0] addrb;
    logic [AW-1:0] addra;
  } obs_t;

  typedef struct {
    logic [AW-1:0] ub_base;
    logic [AW-1:0] wb_base;
    logic [AW-1:0] acc_base;
    int            num_rows;
    logic          accumulate;
  } op_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  mmu_tile_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  mmu_tile_sequencer #(
    .ARRAY_DIM   (AD),
    .ADDR_WIDTH  (AW),
    .FIFO_DEPTH  (F),
    .MMU_LATENCY (L)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic obs_t sample();
    obs_t o;
    o.busy               = bus.busy;
    o.done               = bus.done;
    o.err                = bus.err;
    o.read_wb            = bus.read_wb;
    o.read_ub            = bus.read_ub;
    o.weight_fifo_en     = bus.weight_fifo_en;
    o.mmu_load_weight_en = bus.mmu_load_weight_en;
    o.data_fifo_en       = bus.data_fifo_en;
    o.mm_en              = bus.mm_en;
    o.write_acc          = bus.write_acc;
    o.acc_en             = bus.acc_en;
    o.addrb              = bus.addrb;
    o.addra              = bus.addra;
    return o;
  endfunction

  // Expected outputs k cycles after the start was sampled (k=1 is the first
  // busy cycle). Weight load spans k=1..AD+F+1, stream follows for
  // N+F+L+1 cycles, done on the last cycle.
  function automatic obs_t model(int k, op_t op);
    obs_t e;
    int n, total, ss, c;
    e     = '0;
    n     = op.num_rows;
    total = AD + n + 2 * F + L + 3;
    ss    = AD + F + 2;
    if (k < 1 || k > total) return e;
    e.busy = 1'b1;
    if (k == total) begin
      e.done = 1'b1;
    end else if (k >= ss) begin
      c = k - ss;
      e.mm_en = 1'b1;
      if (c < n) begin
        e.read_ub = 1'b1;
        e.addrb   = AW'(int'(op.ub_base) + c);
      end
      e.data_fifo_en = (c >= 1) && (c <= n + F);
      if (c >= F + L + 1 && c <= n + F + L) begin
        e.write_acc = 1'b1;
        e.addra     = AW'(int'(op.acc_base) + c - F - L - 1);
        e.acc_en    = op.accumulate;
      end
    end else begin
      c = k - 1;
      if (c < AD) begin
        e.read_wb = 1'b1;
        e.addrb   = AW'(int'(op.wb_base) + c);
      end
      e.weight_fifo_en     = (c >= 1) && (c <= AD + F);
      e.mmu_load_weight_en = (c >= F + 1) && (c <= AD + F);
    end
    return e;
  endfunction

  // Scramble non-strobe command inputs so latching is exercised.
  task automatic jumble_params();
    bus.ub_base    = AW'($urandom);
    bus.wb_base    = AW'($urandom);
    bus.acc_base   = AW'($urandom);
    bus.num_rows   = (AW + 1)'($urandom_range(0, 256));
    bus.accumulate = 1'($urandom);
  endtask

  function automatic op_t rand_op(int n_max);
    op_t op;
    op.ub_base    = AW'($urandom);
    op.wb_base    = AW'($urandom);
    op.acc_base   = AW'($urandom);
    op.num_rows   = $urandom_range(1, n_max);
    op.accumulate = 1'($urandom);
    return op;
  endfunction

  // Issue one command and compare every busy cycle against the model.
  // With spam set, start stays high (with random parameters) through the
  // done cycle, and the cycle after done must be idle.
  task automatic run_op(input op_t op, input string name, input bit spam,
                        output int wacc_cnt, output int acc_cnt,
                        output int done_cnt, output int done_k,
                        output logic [AW-1:0] last_addra);
    obs_t got, exp;
    int   total;
    wacc_cnt = 0; acc_cnt = 0; done_cnt = 0; done_k = -1; last_addra = '0;
    total = AD + op.num_rows + 2 * F + L + 3;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.abort      = 1'b0;
    bus.ub_base    = op.ub_base;
    bus.wb_base    = op.wb_base;
    bus.acc_base   = op.acc_base;
    bus.num_rows   = (AW + 1)'(op.num_rows);
    bus.accumulate = op.accumulate;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      got = sample();
      exp = model(k, op);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s k=%0d got=%h expected=%h", name, k, got, exp);
      end
      if (got.write_acc) begin
        wacc_cnt++;
        last_addra = got.addra;
      end
      if (got.acc_en) acc_cnt++;
      if (got.done) begin
        done_cnt++;
        done_k = k;
      end
      jumble_params();
      bus.start = spam;
    end
    if (spam) begin
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL %s_after_done got=%h expected=0", name, got);
      end
      bus.start = 1'b0;
    end
  endtask

  task automatic expect_idle(input string name, input int cycles);
    obs_t got;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL %s cycle=%0d got=%h expected=0", name, i, got);
      end
      jumble_params();
      bus.start = 1'b0;
      bus.abort = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    jumble_params();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sample() !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h expected=0", sample());
    end
    reset_n = 1'b1;
    expect_idle("idle_after_reset", 3);
  endtask

  task automatic test_basic();
    op_t op;
    int wc, ac, dc, dk;
    logic [AW-1:0] la;
    op = '{ub_base: 8'h00, wb_base: 8'h00, acc_base: 8'h00,
           num_rows: 16, accumulate: 1'b0};
    run_op(op, "basic_n16", 1'b0, wc, ac, dc, dk, la);
    checks++;
    if (dk !== 75) begin
      errors++;
      $display("FAIL basic_done_cycle got=%0d expected=75", dk);
    end
    checks++;
    if (wc !== 16 || la !== 8'h0F) begin
      errors++;
      $display("FAIL basic_acc_writes got=%0d/last=%h expected=16/last=0f", wc, la);
    end
  endtask

  task automatic test_wrap();
    op_t op;
    int wc, ac, dc, dk;
    logic [AW-1:0] la;
    op = '{ub_base: 8'hF0, wb_base: 8'hF8, acc_base: 8'h80,
           num_rows: 256, accumulate: 1'b1};
    run_op(op, "wrap_n256", 1'b0, wc, ac, dc, dk, la);
    checks++;
    if (wc !== 256 || la !== 8'h7F || dc !== 1) begin
      errors++;
      $display("FAIL wrap_summary got=writes %0d last %h done %0d expected=writes 256 last 7f done 1",
               wc, la, dc);
    end
  endtask

  task automatic test_accumulate();
    op_t op;
    int wc, ac, dc, dk;
    logic [AW-1:0] la;
    for (int a = 0; a < 2; a++) begin
      op = rand_op(40);
      op.accumulate = 1'(a);
      run_op(op, a ? "accum_on" : "accum_off", 1'b0, wc, ac, dc, dk, la);
      checks++;
      if (ac !== (a ? op.num_rows : 0)) begin
        errors++;
        $display("FAIL accum_count acc=%0d got=%0d expected=%0d",
                 a, ac, a ? op.num_rows : 0);
      end
    end
  endtask

  task automatic test_zero_rows();
    obs_t got, exp;
    @(negedge clk);
    jumble_params();
    bus.num_rows = '0;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    got = sample();
    exp = '0;
    exp.err = 1'b1;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL zero_rows_err got=%h expected=%h", got, exp);
    end
    expect_idle("zero_rows_after", 4);
  endtask

  task automatic test_start_spam();
    op_t op;
    int wc, ac, dc, dk;
    logic [AW-1:0] la;
    op = rand_op(32);
    run_op(op, "start_spam", 1'b1, wc, ac, dc, dk, la);
    checks++;
    if (dc !== 1) begin
      errors++;
      $display("FAIL spam_done_count got=%0d expected=1", dc);
    end
  endtask

  task automatic test_back_to_back();
    int wc, ac, dc, dk;
    logic [AW-1:0] la;
    run_op(rand_op(24), "b2b_first", 1'b0, wc, ac, dc, dk, la);
    run_op(rand_op(24), "b2b_second", 1'b0, wc, ac, dc, dk, la);
  endtask

  task automatic test_abort();
    op_t  op;
    obs_t got, exp;
    int   kab, done_seen;
    int   wc, ac, dc, dk;
    logic [AW-1:0] la;
    op  = rand_op(64);
    kab = AD + F + 2 + 10;  // STREAM c=10
    done_seen = 0;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.ub_base    = op.ub_base;
    bus.wb_base    = op.wb_base;
    bus.acc_base   = op.acc_base;
    bus.num_rows   = (AW + 1)'(op.num_rows);
    bus.accumulate = op.accumulate;
    for (int k = 1; k <= kab; k++) begin
      @(negedge clk);
      got = sample();
      exp = model(k, op);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL abort_pre k=%0d got=%h expected=%h", k, got, exp);
      end
      bus.start = 1'b0;
    end
    bus.abort = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got = sample();
      bus.abort = 1'b0;
      if (got.done) done_seen++;
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL abort_post cycle=%0d got=%h expected=0", i, got);
      end
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done got=%0d expected=0", done_seen);
    end
    run_op(rand_op(20), "after_abort", 1'b0, wc, ac, dc, dk, la);
  endtask

  task automatic test_abort_with_start();
    @(negedge clk);
    jumble_params();
    bus.num_rows = 9'd5;
    bus.start    = 1'b1;
    bus.abort    = 1'b1;
    expect_idle("abort_beats_start", 4);
  endtask

  task automatic test_reset_mid();
    op_t  op;
    obs_t got, exp;
    int   wc, ac, dc, dk;
    logic [AW-1:0] la;
    op = rand_op(32);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.ub_base    = op.ub_base;
    bus.wb_base    = op.wb_base;
    bus.acc_base   = op.acc_base;
    bus.num_rows   = (AW + 1)'(op.num_rows);
    bus.accumulate = op.accumulate;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      got = sample();
      exp = model(k, op);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid_pre k=%0d got=%h expected=%h", k, got, exp);
      end
      bus.start = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (sample() !== '0) begin
      errors++;
      $display("FAIL reset_mid_async got=%h expected=0", sample());
    end
    @(negedge clk);
    reset_n = 1'b1;
    expect_idle("reset_mid_release", 6);
    run_op(rand_op(20), "after_reset", 1'b0, wc, ac, dc, dk, la);
  endtask

  task automatic test_random();
    int wc, ac, dc, dk;
    logic [AW-1:0] la;
    for (int i = 0; i < 6; i++) begin
      run_op(rand_op(256), "random_op", 1'($urandom_range(0, 1)),
             wc, ac, dc, dk, la);
      if ($urandom_range(0, 1) == 1) expect_idle("random_gap", $urandom_range(1, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_accumulate();
    test_zero_rows();
    test_start_spam();
    test_back_to_back();
    test_abort();
    test_abort_with_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
